// File: rtl/alu_ctrl.sv
// Single-issue sequencer for the 8-bit ALU: owns ACC, CY and a 4x8 register file,
// accepts one instruction per 3 cycles (IDLE -> EXEC -> WB) over valid/ready.
module alu_ctrl (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    input  logic [7:0] IN_INSTR,
    output logic       IN_READY,
    input  logic       WR_EN,
    input  logic [1:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_R,
    output logic [2:0] ALU_OP,
    output logic       ALU_CY,
    input  logic [7:0] ALU_RES,
    input  logic       ALU_CO,
    output logic [7:0] ACC,
    output logic       CY,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [2:0] OP_ST  = 3'd7;

    logic [1:0] state;
    logic [2:0] ir_op;
    logic [1:0] ir_n;
    logic       ir_ce;
    logic [7:0] acc;
    logic       cy;
    logic [7:0] rf [4];

    logic in_exec;
    logic accept;
    logic unused_reserved;

    assign in_exec  = (state == S_EXEC);
    assign accept   = IN_VALID && (state == S_IDLE);

    // The reserved instruction bits are never captured.
    assign unused_reserved = ^IN_INSTR[1:0];

    assign IN_READY = (state == S_IDLE);
    assign BUSY     = (state != S_IDLE);
    assign DONE     = (state == S_WB);

    assign ALU_A  = acc;
    assign ALU_R  = rf[ir_n];
    assign ALU_OP = in_exec ? ir_op : 3'b111;
    assign ALU_CY = in_exec & cy & ir_ce;

    assign ACC = acc;
    assign CY  = cy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            ir_op <= '0;
            ir_n  <= '0;
            ir_ce <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    ir_op <= IN_INSTR[7:5];
                    ir_n  <= IN_INSTR[4:3];
                    ir_ce <= IN_INSTR[2];
                    state <= S_EXEC;
                end
                S_EXEC:  state <= S_WB;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc <= '0;
            cy  <= 1'b0;
        end else if (in_exec && ir_op != OP_ST) begin
            acc <= ALU_RES;
            cy  <= ALU_CO;
        end
    end

    // NOTE: the register file is small and architecturally visible, so it is
    // reset explicitly rather than left to power-up contents.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (in_exec && ir_op == OP_ST) begin
            rf[ir_n] <= acc;
        end else if (WR_EN && state == S_IDLE) begin
            // Host writes are only honoured while idle; an accept in the same
            // cycle lets the instruction see the freshly written value.
            rf[WR_ADDR] <= WR_DATA;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a behavioural ALU closes the loop and an
// arithmetic reference model predicts ACC/CY/register contents.
module tb_alu_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       IN_VALID;
    logic [7:0] IN_INSTR;
    logic       IN_READY;
    logic       WR_EN;
    logic [1:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic [7:0] ALU_A;
    logic [7:0] ALU_R;
    logic [2:0] ALU_OP;
    logic       ALU_CY;
    logic [7:0] alu_res;
    logic       alu_co;
    logic [7:0] ACC;
    logic       CY;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_acc;
    int m_cy;
    int m_reg [4];

    alu_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_INSTR(IN_INSTR),
        .IN_READY(IN_READY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ALU_A(ALU_A), .ALU_R(ALU_R), .ALU_OP(ALU_OP), .ALU_CY(ALU_CY),
        .ALU_RES(alu_res), .ALU_CO(alu_co), .ACC(ACC), .CY(CY),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Combinational ALU standing in for the real instance.
    always_comb begin
        logic [8:0] wide;
        wide    = '0;
        alu_res = '0;
        alu_co  = 1'b0;
        case (ALU_OP)
            3'd0: begin wide = {1'b0, ALU_A} + {1'b0, ALU_R} + {8'd0, ALU_CY};
                        alu_res = wide[7:0]; alu_co = wide[8]; end
            3'd1: begin wide = {1'b0, ALU_A} - {1'b0, ALU_R} - {8'd0, ALU_CY};
                        alu_res = wide[7:0]; alu_co = wide[8]; end
            3'd2: alu_res = ALU_A | ALU_R;
            3'd3: alu_res = ALU_A & ALU_R;
            3'd4: alu_res = ALU_A ^ ALU_R;
            3'd5: alu_res = ~ALU_A;
            3'd6: alu_res = ALU_R;
            default: alu_res = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int op, input int n, input int ce);
        logic [7:0] v;
        v = {op[2:0], n[1:0], ce[0], 2'b00};
        v[1:0] = 2'($urandom_range(0, 3));
        return v;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_cy  = 0;
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
    endtask

    task automatic model_apply(input logic [7:0] ins);
        int op, n, cin, a, r, t;
        op  = int'(ins[7:5]);
        n   = int'(ins[4:3]);
        cin = (m_cy != 0 && ins[2]) ? 1 : 0;
        a   = m_acc;
        r   = m_reg[n];
        case (op)
            0: begin t = a + r + cin; m_acc = t % 256; m_cy = (t > 255) ? 1 : 0; end
            1: begin t = a - r - cin; m_acc = (t + 256) % 256; m_cy = (t < 0) ? 1 : 0; end
            2: begin m_acc = a | r; m_cy = 0; end
            3: begin m_acc = a & r; m_cy = 0; end
            4: begin m_acc = a ^ r; m_cy = 0; end
            5: begin m_acc = 255 - a; m_cy = 0; end
            6: begin m_acc = r; m_cy = 0; end
            default: m_reg[n] = a;
        endcase
    endtask

    // Called at a falling edge while idle; returns at a falling edge while idle.
    task automatic host_write(input int addr, input int data);
        WR_EN = 1'b1; WR_ADDR = addr[1:0]; WR_DATA = data[7:0];
        @(posedge CLK); #1;
        WR_EN = 1'b0;
        m_reg[addr] = data;
        @(negedge CLK);
    endtask

    task automatic exec_instr(input logic [7:0] ins, input bit wr_same, input int wa,
                              input int wd, input bit wr_exec);
        int waited, exp_r, exp_a, exp_cin;
        IN_VALID = 1'b1; IN_INSTR = ins;
        WR_EN = wr_same; WR_ADDR = wa[1:0]; WR_DATA = wd[7:0];
        waited = 0;
        while (!IN_READY && waited < 10) begin @(negedge CLK); waited++; end
        if (!IN_READY) begin
            check("accept_timeout", 32'd0, 32'd1);
            IN_VALID = 1'b0; WR_EN = 1'b0;
            return;
        end
        if (wr_same) m_reg[wa] = wd;
        exp_r   = m_reg[int'(ins[4:3])];
        exp_a   = m_acc;
        exp_cin = (m_cy != 0 && ins[2]) ? 1 : 0;
        model_apply(ins);
        @(posedge CLK); #1;
        IN_VALID = 1'b0; IN_INSTR = 8'($urandom); WR_EN = 1'b0;
        @(negedge CLK);
        check("exec_busy",  BUSY, 1);
        check("exec_ready", IN_READY, 0);
        check("exec_done",  DONE, 0);
        check("exec_op",    ALU_OP, ins[7:5]);
        check("exec_cin",   ALU_CY, exp_cin);
        check("exec_a",     ALU_A, exp_a);
        check("exec_r",     ALU_R, exp_r);
        if (wr_exec) begin
            WR_EN = 1'b1; WR_ADDR = wa[1:0]; WR_DATA = ~wd[7:0];
        end
        @(posedge CLK); #1;
        WR_EN = 1'b0;
        @(negedge CLK);
        check("wb_done",  DONE, 1);
        check("wb_ready", IN_READY, 0);
        check("wb_op",    ALU_OP, 3'b111);
        check("wb_acc",   ACC, m_acc);
        check("wb_cy",    CY, m_cy);
        @(negedge CLK);
        check("post_done",  DONE, 0);
        check("post_ready", IN_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] tp [4];
        int acc_cyc [4];
        int exp_q [$];
        int idx, cyc, dones, e;
        bit taking;

        RST_N = 1'b0; IN_VALID = 1'b0; IN_INSTR = '0;
        WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        check("rst_ready",  IN_READY, 1);
        check("rst_busy",   BUSY, 0);
        check("rst_done",   DONE, 0);
        check("rst_acc",    ACC, 0);
        check("rst_cy",     CY, 0);
        check("rst_op",     ALU_OP, 3'b111);
        check("rst_cin",    ALU_CY, 0);
        check("rst_alu_a",  ALU_A, 0);
        check("rst_alu_r",  ALU_R, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Reset abandons an instruction in EXEC
        host_write(0, 8'h01);
        exec_instr(enc(6, 0, 0), 0, 0, 0, 0);
        IN_VALID = 1'b1; IN_INSTR = enc(0, 0, 0);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("abort_in_exec", BUSY, 1);
        RST_N = 1'b0;
        #1;
        check("abort_acc",  ACC, 0);
        check("abort_cy",   CY, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_reg",  ALU_R, 0);
        @(negedge CLK);
        check("abort_no_done", DONE, 0);
        RST_N = 1'b1;
        model_reset();
        @(negedge CLK);
        check("abort_ready", IN_READY, 1);

        // ADD with wrap, then carry-in
        host_write(0, 8'h01);
        host_write(1, 8'hFF);
        exec_instr(enc(6, 1, 0), 0, 0, 0, 0);
        exec_instr(enc(0, 0, 0), 0, 0, 0, 0);
        check("add_wrap_acc", ACC, 8'h00);
        check("add_wrap_cy",  CY, 1);
        exec_instr(enc(0, 0, 1), 0, 0, 0, 0);
        check("add_cin_acc", ACC, 8'h02);

        // SUB borrow chain
        host_write(2, 8'h00);
        exec_instr(enc(6, 2, 0), 0, 0, 0, 0);
        host_write(2, 8'h01);
        exec_instr(enc(1, 2, 0), 0, 0, 0, 0);
        check("sub_borrow_acc", ACC, 8'hFF);
        check("sub_borrow_cy",  CY, 1);
        exec_instr(enc(1, 2, 1), 0, 0, 0, 0);
        check("sub_chain_acc", ACC, 8'hFD);
        check("sub_chain_cy",  CY, 0);

        // Logic and store
        host_write(3, 8'hF0);
        exec_instr(enc(6, 3, 0), 0, 0, 0, 0);
        host_write(3, 8'h3C);
        exec_instr(enc(4, 3, 0), 0, 0, 0, 0);
        check("xor_acc", ACC, 8'hCC);
        exec_instr(enc(5, 0, 0), 0, 0, 0, 0);
        check("not_acc", ACC, 8'h33);
        exec_instr(enc(7, 1, 0), 0, 0, 0, 0);
        check("st_acc_kept", ACC, 8'h33);
        host_write(2, 8'h00);
        exec_instr(enc(6, 2, 0), 0, 0, 0, 0);
        exec_instr(enc(6, 1, 0), 0, 0, 0, 0);
        check("ld_after_st", ACC, 8'h33);

        // Host write arbitration
        exec_instr(enc(6, 0, 0), 1, 0, 8'hAA, 1);
        check("wr_same_edge", ACC, 8'hAA);
        exec_instr(enc(6, 2, 0), 0, 0, 0, 0);
        exec_instr(enc(6, 0, 0), 0, 0, 0, 0);
        check("wr_exec_dropped", ACC, 8'hAA);

        // Throughput with IN_VALID held high
        host_write(1, 8'h5A);
        host_write(2, 8'h0F);
        host_write(3, 8'hC3);
        tp[0] = enc(0, 1, 0);
        tp[1] = enc(4, 2, 0);
        tp[2] = enc(1, 3, 1);
        tp[3] = enc(2, 0, 0);
        idx = 0; cyc = 0; dones = 0;
        IN_VALID = 1'b1; IN_INSTR = tp[0];
        while (cyc < 40 && (idx < 4 || dones < 4)) begin
            if (DONE) begin
                dones++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("tp_result", {CY, ACC}, e);
            end
            if (BUSY) check("tp_ready_low", IN_READY, 0);
            taking = IN_READY && IN_VALID;
            if (taking) begin
                acc_cyc[idx] = cyc;
                model_apply(tp[idx]);
                exp_q.push_back(m_cy * 256 + m_acc);
                idx++;
            end
            @(posedge CLK); #1;
            if (taking) begin
                if (idx < 4) IN_INSTR = tp[idx];
                else IN_VALID = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        IN_VALID = 1'b0;
        check("tp_accepts", idx, 4);
        check("tp_dones", dones, 4);
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < idx) check("tp_spacing", acc_cyc[i + 1] - acc_cyc[i], 3);
        end

        // Randomized instructions and host writes against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) host_write($urandom_range(0, 3), $urandom_range(0, 255));
            exec_instr(8'($urandom), bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                       $urandom_range(0, 255), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
